// File: rtl/hevc_luma_fir_pipe.sv
// rtl/hevc_luma_fir_pipe.sv - pipelined 8-tap HEVC luma sub-pel filter, phase selected per sample
// Three register stages (partial products, sum, output) behind valid/ready; stalls back-pressure stage by stage.
module hevc_luma_fir_pipe #(
  parameter int BIT_DEPTH = 8,
  parameter int TAG_W     = 8,
  parameter int ACC_W     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*BIT_DEPTH-1:0] in_pixels,
  input  logic [1:0]             in_frac,
  input  logic                   in_clip_en,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sample,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int PP_W = BIT_DEPTH + 8;

  typedef logic signed [PP_W-1:0]  pp_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t RND_BIAS = acc_t'(32);
  localparam acc_t MAX_PIX  = acc_t'((1 << BIT_DEPTH) - 1);

  // Stage load enables: a stage takes new data when it is empty or its content moves on.
  logic s1_load, s2_load, s3_load;
  logic s1_valid, s2_valid;

  assign s3_load  = !out_valid || out_ready;
  assign s2_load  = !s2_valid || s3_load;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  pp_t px   [8];
  pp_t pr   [4];
  pp_t pp_d [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      px[i]   = {8'b0, in_pixels[i*BIT_DEPTH +: BIT_DEPTH]};
      pp_d[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      pr[i] = px[i] + px[7-i];
    end
    case (in_frac)
      2'd0: begin
        pp_d[3] = px[3] <<< 6;
      end
      2'd1: begin
        pp_d[0] = -px[0];
        pp_d[1] = px[1] <<< 2;
        pp_d[2] = -((px[2] <<< 3) + (px[2] <<< 1));
        pp_d[3] = (px[3] <<< 6) - (px[3] <<< 2) - (px[3] <<< 1);
        pp_d[4] = (px[4] <<< 4) + px[4];
        pp_d[5] = -((px[5] <<< 2) + px[5]);
        pp_d[6] = px[6];
      end
      2'd2: begin
        // Half-pel is symmetric: fold the tap pairs first, then weight 4 sums.
        pp_d[0] = -pr[0];
        pp_d[1] = pr[1] <<< 2;
        pp_d[2] = -((pr[2] <<< 3) + (pr[2] <<< 1) + pr[2]);
        pp_d[3] = (pr[3] <<< 5) + (pr[3] <<< 3);
      end
      default: begin
        pp_d[1] = px[1];
        pp_d[2] = -((px[2] <<< 2) + px[2]);
        pp_d[3] = (px[3] <<< 4) + px[3];
        pp_d[4] = (px[4] <<< 6) - (px[4] <<< 2) - (px[4] <<< 1);
        pp_d[5] = -((px[5] <<< 3) + (px[5] <<< 1));
        pp_d[6] = px[6] <<< 2;
        pp_d[7] = -px[7];
      end
    endcase
  end

  pp_t              s1_pp [8];
  logic [1:0]       s1_frac;
  logic             s1_clip;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_frac  <= '0;
      s1_clip  <= 1'b0;
      s1_tag   <= '0;
      for (int i = 0; i < 8; i++) s1_pp[i] <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_frac <= in_frac;
        s1_clip <= in_clip_en;
        s1_tag  <= in_tag;
        for (int i = 0; i < 8; i++) s1_pp[i] <= pp_d[i];
      end
    end
  end

  acc_t sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (s1_frac != 2'd2 || i < 4) sum_d = sum_d + acc_t'(s1_pp[i]);
    end
  end

  acc_t             s2_sum;
  logic             s2_clip;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_clip  <= 1'b0;
      s2_tag   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum  <= sum_d;
        s2_clip <= s1_clip;
        s2_tag  <= s1_tag;
      end
    end
  end

  acc_t rnd, res;

  // Final samples round and clamp to pixel range; intermediates only drop extra precision.
  always_comb begin
    rnd = (s2_sum + RND_BIAS) >>> 6;
    res = s2_sum >>> (BIT_DEPTH - 8);
    if (s2_clip) begin
      if (rnd[ACC_W-1])      res = '0;
      else if (rnd > MAX_PIX) res = MAX_PIX;
      else                    res = rnd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_tag    <= '0;
    end else if (s3_load) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sample <= res;
        out_tag    <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_hevc_luma_fir_pipe.sv
// tb/tb_hevc_luma_fir_pipe.sv - self-checking bench for hevc_luma_fir_pipe
module tb_hevc_luma_fir_pipe;

  localparam int BD = 8;
  localparam int TW = 8;
  localparam int AW = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [8*BD-1:0] in_pixels = '0;
  logic [1:0]      in_frac = '0;
  logic            in_clip_en = 1'b0;
  logic [TW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_sample;
  logic [TW-1:0]   out_tag;

  logic ready_man = 1'b1;
  logic rand_mode = 1'b0;
  logic rnd_bit   = 1'b1;
  assign out_ready = rand_mode ? rnd_bit : ready_man;

  always #5 clock = ~clock;

  hevc_luma_fir_pipe #(.BIT_DEPTH(BD), .TAG_W(TW), .ACC_W(AW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .in_frac(in_frac), .in_clip_en(in_clip_en), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sample(out_sample), .out_tag(out_tag)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  int last_lat = 0;
  logic [AW-1:0] last_sample = '0;
  logic [TW-1:0] last_tag = '0;
  bit lat_chk = 1'b1;

  int coef [4][8] = '{
    '{ 0, 0,   0, 64,  0,   0, 0,  0},
    '{-1, 4, -10, 58, 17,  -5, 1,  0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{ 0, 1,  -5, 17, 58, -10, 4, -1}
  };

  typedef struct {
    logic [AW-1:0] s;
    logic [TW-1:0] t;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc_q[$];

  typedef struct {
    logic [8*BD-1:0] pix;
    logic [1:0]      frac;
    logic            clip;
    logic [AW-1:0]   exp;
  } vec_t;

  vec_t vt[9];

  function automatic logic [AW-1:0] model(input logic [8*BD-1:0] p, input logic [1:0] f, input logic c);
    int s, r;
    s = 0;
    for (int i = 0; i < 8; i++) s += coef[f][i] * int'(p[i*BD +: BD]);
    if (c) begin
      r = (s + 32) >>> 6;
      if (r < 0) r = 0;
      if (r > (1 << BD) - 1) r = (1 << BD) - 1;
    end else begin
      r = s >>> (BD - 8);
    end
    return r[AW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc++;
  always @(posedge clock) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // Scoreboard: every visible output must match the oldest outstanding beat.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          chk("sample", 32'(out_sample), 32'(exp_q[0].s));
          chk("tag", 32'(out_tag), 32'(exp_q[0].t));
          if (out_ready) begin
            last_lat = cyc - exp_q[0].acc;
            if (lat_chk) chk("latency", 32'(last_lat), 32'd3);
            last_sample = out_sample;
            last_tag    = out_tag;
            n_out++;
            pop_cyc_q.push_back(cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{model(in_pixels, in_frac, in_clip_en), in_tag, cyc});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [8*BD-1:0] p, input logic [1:0] f, input logic c, input logic [TW-1:0] t);
    int k;
    in_pixels = p; in_frac = f; in_clip_en = c; in_tag = t; in_valid = 1'b1;
    k = 0;
    @(negedge clock);
    while (!in_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (k >= 100) chk("accept_timeout", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic wait_outs(input int n);
    int k;
    k = 0;
    while (n_out < n && k < 200) begin
      tick();
      k++;
    end
    if (n_out < n) chk("drain_timeout", 32'(n_out), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n0, idx0, k, g;
    logic [8*BD-1:0] p;

    vt[0] = '{{8{8'd100}}, 2'd0, 1'b1, 16'd100};
    vt[1] = '{{8{8'd100}}, 2'd1, 1'b1, 16'd100};
    vt[2] = '{{8{8'd100}}, 2'd2, 1'b1, 16'd100};
    vt[3] = '{{8{8'd100}}, 2'd3, 1'b1, 16'd100};
    vt[4] = '{64'h000000FF_FF000000, 2'd2, 1'b1, 16'd255};
    vt[5] = '{64'h00000000_00FF0000, 2'd1, 1'b1, 16'd0};
    vt[6] = '{64'h00000000_00FF0000, 2'd1, 1'b0, 16'hF60A};
    vt[7] = '{64'h0000000A_00000000, 2'd3, 1'b1, 16'd9};
    vt[8] = '{{8{8'd100}}, 2'd2, 1'b0, 16'h1900};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sample", 32'(out_sample), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    for (int i = 0; i < 9; i++) begin
      n0 = n_out;
      send(vt[i].pix, vt[i].frac, vt[i].clip, 8'(i + 1));
      in_valid = 1'b0;
      wait_outs(n0 + 1);
      chk("vec_sample", 32'(last_sample), 32'(vt[i].exp));
      chk("vec_latency", 32'(last_lat), 32'd3);
      chk("vec_tag", 32'(last_tag), 32'(i + 1));
    end

    n0 = n_out;
    idx0 = pop_cyc_q.size();
    for (int i = 0; i < 20; i++) send(64'h0000000A_00000000, 2'd3, 1'b1, 8'(8'h20 + i));
    in_valid = 1'b0;
    wait_outs(n0 + 20);
    chk("stream_count", 32'(pop_cyc_q.size() - idx0), 32'd20);
    if (pop_cyc_q.size() >= idx0 + 20)
      chk("stream_span", 32'(pop_cyc_q[idx0+19] - pop_cyc_q[idx0]), 32'd19);

    lat_chk = 1'b0;
    ready_man = 1'b0;
    n0 = n_out;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_pixels = {8{8'(20 + 30 * k)}}; in_frac = 2'(k); in_clip_en = 1'b1;
      in_tag = 8'(8'h80 + k); in_valid = (k < 5);
      @(negedge clock);
      if (in_valid && in_ready) k++;
      tick();
    end
    chk("stall_accepted", 32'(k), 32'd3);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    ready_man = 1'b1;
    idx0 = pop_cyc_q.size();
    g = 0;
    while (k < 5 && g < 20) begin
      in_pixels = {8{8'(20 + 30 * k)}}; in_frac = 2'(k); in_clip_en = 1'b1;
      in_tag = 8'(8'h80 + k); in_valid = 1'b1;
      @(negedge clock);
      if (in_ready) k++;
      tick();
      g++;
    end
    in_valid = 1'b0;
    wait_outs(n0 + 5);
    chk("stall_delivered", 32'(n_out - n0), 32'd5);
    if (pop_cyc_q.size() >= idx0 + 5)
      chk("stall_span", 32'(pop_cyc_q[idx0+4] - pop_cyc_q[idx0]), 32'd4);
    lat_chk = 1'b1;

    send({8{8'd100}}, 2'd0, 1'b1, 8'h50);
    send({8{8'd200}}, 2'd2, 1'b1, 8'h51);
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sample", 32'(out_sample), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    repeat (3) tick();
    n0 = n_out;
    send({8{8'd77}}, 2'd3, 1'b1, 8'h60);
    in_valid = 1'b0;
    wait_outs(n0 + 1);
    chk("post_rst_sample", 32'(last_sample), 32'd77);
    chk("post_rst_latency", 32'(last_lat), 32'd3);
    chk("post_rst_tag", 32'(last_tag), 32'h60);

    lat_chk = 1'b0;
    rand_mode = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < 8; b++) begin
        case ($urandom_range(0, 3))
          0:       p[b*BD +: BD] = '0;
          1:       p[b*BD +: BD] = '1;
          default: p[b*BD +: BD] = BD'($urandom);
        endcase
      end
      send(p, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'(i));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    rand_mode = 1'b0;
    ready_man = 1'b1;
    wait_outs(n0 + 300);
    chk("random_count", 32'(n_out - n0), 32'd300);
    repeat (4) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hevc_luma_fir_pipe.md
Name: hevc_luma_fir_pipe

Overview:
- Parametrised, pipelined 8-tap HEVC luma sub-pixel interpolation filter.
- Replaces separate fixed quarter, half and three-quarter filter instances with one block that selects the fractional phase per sample.
- Adds rounding, true two-sided clipping, an unclipped intermediate mode for the first pass of 2D (H then V) interpolation, a tag passthrough and valid/ready flow control.
- Sits between the reference-pixel line buffer and the prediction sample store.

Parameters:
- BIT_DEPTH, 8, sample bit depth (8..12).
- TAG_W, 8, width of the sideband tag carried alongside each sample.
- ACC_W, 16, signed output/intermediate width. Must be >= BIT_DEPTH+8.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_pixels  in  8*BIT_DEPTH  flattened taps. p0 = bits [BIT_DEPTH-1:0] ... p7 = top slice.
- in_frac  in  2  phase select: 0 integer, 1 quarter (A), 2 half (B), 3 three-quarter (C).
- in_clip_en  in  1  1 = final sample (round + clip); 0 = intermediate (unclipped).
- in_tag  in  TAG_W  sideband, returned unmodified with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sample  out  ACC_W  result. Signed in intermediate mode; zero-extended BIT_DEPTH value in final mode.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all stage valid flags 0, out_valid=0, out_sample=0, out_tag=0.
  - in_ready=1 in the first cycle after deassert.
  - Beats in flight are discarded.
- Coefficients, taps p0..p7:
  - frac0: 0,0,0,64,0,0,0,0
  - frac1: -1,4,-10,58,17,-5,1,0
  - frac2: -1,4,-11,40,40,-11,4,-1
  - frac3: 0,1,-5,17,58,-10,4,-1
- Multiplierless: shift-and-add only; frac2 uses pre-added symmetric pairs.
- Pipeline, 3 stages:
  - S1 registers pixels, frac, clip_en, tag and per-tap partial products.
  - S2 registers the signed sum, ACC_W bits. Range for BIT_DEPTH=8 is -24*255..88*255; no overflow for any legal input.
  - S3 forms the output.
- S3 output forming:
  - clip_en=1: out = (sum + 32) >>> 6, arithmetic shift, then clamp to [0, 2^BIT_DEPTH-1].
  - clip_en=0: out = sum >>> (BIT_DEPTH-8), no rounding, no clamp, sign preserved.
- Latency and throughput:
  - Latency 3 cycles from an accepted beat (in_valid && in_ready at edge N) to out_valid at edge N+3, if not stalled.
  - Throughput 1 beat/cycle.
- Flow control:
  - Stage k advances when its successor is empty or advancing.
  - The output stage advances when !out_valid || out_ready.
  - in_ready = !s1_valid || s1_advances (combinational from out_ready through the chain).
  - Up to 3 beats are held while stalled; none are dropped or duplicated; order is preserved.
- out_sample and out_tag hold stable while out_valid && !out_ready.
- in_frac and in_clip_en are captured per beat. Mixed modes back-to-back are legal.
- Simultaneous output pop and input push at full occupancy: both occur; occupancy is unchanged.

Test Plan (BIT_DEPTH=8):
- All p=100, frac 0..3, clip_en=1, one beat each → out_sample=100 for each, out_valid exactly 3 cycles after acceptance, tags returned in order.
- frac=2, p3=p4=255, others 0, clip_en=1 → sum 20400, rounded 319, clamped out=255.
- frac=1, p2=255, others 0: clip_en=1 → out=0 (negative clamp); clip_en=0 → out=16'hF60A (-2550).
- frac=3, p4=10, others 0, clip_en=1 → (580+32)>>6 = 9; a continuous stream of 20 such beats → 20 outputs on consecutive cycles.
- Hold out_ready=0 while 5 beats are offered → in_ready falls after 3 are accepted, outputs stay stable. Release → all 5 delivered in order with correct tags, no gaps beyond the pipeline.
- Assert reset asynchronously mid-stream with 2 beats in flight → out_valid=0 and out_sample=0 immediately, before the next edge. After deassert, the first new beat emerges 3 cycles after acceptance and no stale data appears.
